// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: state encoding, select codes
// and the small combinational units (ALU, shifter, immediate extender).
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_t;

  localparam logic [2:0] PCN_PC4  = 3'd0;
  localparam logic [2:0] PCN_BR   = 3'd1;
  localparam logic [2:0] PCN_JUMP = 3'd2;
  localparam logic [2:0] PCN_RS   = 3'd3;

  localparam logic [1:0] RES_ALU   = 2'd0;
  localparam logic [1:0] RES_MEM   = 2'd1;
  localparam logic [1:0] RES_SHIFT = 2'd2;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [4:0] RA = 5'd31;

  localparam logic [1:0] EXT_SIGN  = 2'd0;
  localparam logic [1:0] EXT_ZERO  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [3:0] SH_SLL = 4'd0;
  localparam logic [3:0] SH_SRL = 4'd1;
  localparam logic [3:0] SH_SRA = 4'd2;

  function automatic logic [31:0] alu_f(input logic [3:0] mode, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (mode)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOR:   r = ~(a | b);
      ALU_SLT:   r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {31'd0, a < b};
      ALU_PASSB: r = b;
      default:   r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] shift_f(input logic [3:0] mode, input logic [31:0] val,
                                          input logic [4:0] amt);
    logic [31:0] r;
    case (mode)
      SH_SLL:  r = val << amt;
      SH_SRL:  r = val >> amt;
      SH_SRA:  r = 32'($signed(val) >>> amt);
      default: r = val << amt;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ext_f(input logic [1:0] mode, input logic [15:0] imm);
    logic [31:0] r;
    case (mode)
      EXT_ZERO:  r = {16'd0, imm};
      EXT_UPPER: r = {imm, 16'd0};
      default:   r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_datapath_seq.sv
// Sequencer for the multi-cycle datapath: state machine, memory wait counter,
// register-load enables and the retire/fault flags.
module mc_seq
  import mc_datapath_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   mem_ready,
  input  logic   mem_rd_c,
  input  logic   mem_we_c,
  input  logic   we_c,
  output state_t state,
  output logic   mem_req,
  output logic   ir_en,
  output logic   ab_en,
  output logic   alu_en,
  output logic   mdr_en,
  output logic   pc_en,
  output logic   rf_en,
  output logic   retire,
  output logic   fault
);

  localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

  logic [31:0] wait_cnt;
  logic        hs;
  logic        to_hit;

  // Reset kills the request immediately, before the state register settles.
  assign mem_req = !rst && (state == ST_FETCH || state == ST_MEM);
  assign hs      = mem_req && mem_ready;
  assign to_hit  = (TIMEOUT != 32'd0) && ((wait_cnt + 32'd1) == TIMEOUT);

  assign ir_en  = (state == ST_FETCH) && hs;
  assign ab_en  = (state == ST_DECODE);
  assign alu_en = (state == ST_EXEC);
  assign mdr_en = (state == ST_MEM) && hs && !mem_we_c;
  assign pc_en  = (state == ST_WB) || ((state == ST_MEM) && hs && mem_we_c);
  assign rf_en  = (state == ST_WB) && we_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RST;
      wait_cnt <= 32'd0;
      retire   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_RST:    state <= ST_FETCH;
        ST_FETCH, ST_MEM: begin
          if (hs) begin
            wait_cnt <= 32'd0;
            if (state == ST_FETCH) begin
              state <= ST_DECODE;
            end else if (mem_we_c) begin
              state  <= ST_FETCH;
              retire <= 1'b1;
            end else begin
              state <= ST_WB;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
            if (to_hit) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end
        end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC:   state <= (mem_rd_c || mem_we_c) ? ST_MEM : ST_WB;
        ST_WB: begin
          state  <= ST_FETCH;
          retire <= 1'b1;
        end
        ST_FAULT:  state <= ST_FAULT;
        default:   state <= ST_RST;
      endcase
    end
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath sharing one req/ready memory port between
// instruction fetch and load/store, driven by the external main decoder.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [5:0]  op_c,
  output logic [5:0]  funct,
  output logic        zero,
  input  logic        argB_c,
  input  logic        we_c,
  input  logic        sh_d_c,
  input  logic        wd_c,
  input  logic [1:0]  dest_reg_c,
  input  logic [1:0]  result_c,
  input  logic [1:0]  ext_c,
  input  logic [2:0]  pc_next_c,
  input  logic [3:0]  alu_c,
  input  logic [3:0]  us,
  input  logic        mem_rd_c,
  input  logic        mem_we_c,
  output logic        retire,
  output logic        fault,
  output logic [31:0] pc_val
);

  state_t state;
  logic ir_en, ab_en, alu_en, mdr_en, pc_en, rf_en;

  logic [31:0] pc, pc4, ir, a, b, aluout, mdr;
  logic [31:0] rf [0:31];

  logic [4:0]  rs, rt, dest;
  logic [31:0] rs_val, rt_val, imm_ext, opb, c, sh, br_target, jmp_target, pc_next, wd;

  mc_seq #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_seq (
    .clk      (clk),
    .rst      (reset),
    .mem_ready(mem_ready),
    .mem_rd_c (mem_rd_c),
    .mem_we_c (mem_we_c),
    .we_c     (we_c),
    .state    (state),
    .mem_req  (mem_req),
    .ir_en    (ir_en),
    .ab_en    (ab_en),
    .alu_en   (alu_en),
    .mdr_en   (mdr_en),
    .pc_en    (pc_en),
    .rf_en    (rf_en),
    .retire   (retire),
    .fault    (fault)
  );

  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign imm_ext    = ext_f(ext_c, ir[15:0]);
  assign opb        = argB_c ? imm_ext : b;
  assign c          = alu_f(alu_c, a, opb);
  assign sh         = shift_f(us, b, sh_d_c ? a[4:0] : ir[10:6]);
  assign zero       = (c == 32'd0);
  assign br_target  = pc4 + (imm_ext << 2);
  assign jmp_target = {pc4[31:28], ir[25:0], 2'b00};
  assign wd         = wd_c ? pc4 : ((result_c == RES_MEM) ? mdr : aluout);

  always_comb begin
    case (pc_next_c)
      PCN_BR:   pc_next = br_target;
      PCN_JUMP: pc_next = jmp_target;
      PCN_RS:   pc_next = a;
      default:  pc_next = pc4;
    endcase
  end

  always_comb begin
    case (dest_reg_c)
      DST_RT:  dest = rt;
      DST_RA:  dest = RA;
      default: dest = ir[15:11];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      pc4    <= 32'd0;
      ir     <= 32'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      aluout <= 32'd0;
      mdr    <= 32'd0;
    end else begin
      if (ir_en) begin
        ir  <= mem_rdata;
        pc4 <= pc + 32'd4;
      end
      if (ab_en) begin
        a <= rs_val;
        b <= rt_val;
      end
      if (alu_en) aluout <= (result_c == RES_SHIFT) ? sh : c;
      if (mdr_en) mdr <= mem_rdata;
      if (pc_en) pc <= pc_next;
    end
  end

  // Register 0 is never stored; reads of it are forced to zero above.
  always_ff @(posedge clk) begin
    if (rf_en && dest != 5'd0) rf[dest] <= wd;
  end

  assign mem_addr  = (state == ST_MEM) ? aluout : pc;
  assign mem_wdata = b;
  assign mem_we    = mem_req && (state == ST_MEM) && mem_we_c;
  assign instr     = ir;
  assign op_c      = ir[31:26];
  assign funct     = ir[5:0];
  assign pc_val    = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// Randomized bench for mc_datapath: a decoder drives the control inputs and an
// instruction-level model predicts PCs, memory traffic and cycle counts.
module tb_mc_datapath;
  import mc_datapath_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, instr, pc_val;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, zero, retire, fault;
  logic        mem_ready = 1'b0;
  logic [5:0]  op_c, funct;
  logic        argB_c, we_c, sh_d_c, wd_c, mem_rd_c, mem_we_c;
  logic [1:0]  dest_reg_c, result_c, ext_c;
  logic [2:0]  pc_next_c;
  logic [3:0]  alu_c, us;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;

  logic [31:0] rf_m [0:31];
  logic [31:0] dm [logic [31:0]];
  logic [31:0] pc_m;
  logic [5:0]  fn_tab [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ready && mem_we) wr_cnt <= wr_cnt + 1;
  end

  mc_datapath #(.RESET_PC(RST_PC), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
    .instr(instr), .op_c(op_c), .funct(funct), .zero(zero), .argB_c(argB_c),
    .we_c(we_c), .sh_d_c(sh_d_c), .wd_c(wd_c), .dest_reg_c(dest_reg_c),
    .result_c(result_c), .ext_c(ext_c), .pc_next_c(pc_next_c), .alu_c(alu_c),
    .us(us), .mem_rd_c(mem_rd_c), .mem_we_c(mem_we_c), .retire(retire),
    .fault(fault), .pc_val(pc_val)
  );

  // Main decoder: control set is a function of the instruction register (and zero for branches)
  always_comb begin
    argB_c = 1'b0; we_c = 1'b0; sh_d_c = 1'b0; wd_c = 1'b0;
    dest_reg_c = DST_RD; result_c = RES_ALU; ext_c = EXT_SIGN; pc_next_c = PCN_PC4;
    alu_c = ALU_ADD; us = SH_SLL; mem_rd_c = 1'b0; mem_we_c = 1'b0;
    case (op_c)
      6'h00: begin
        we_c = 1'b1;
        case (funct)
          6'h20: alu_c = ALU_ADD;
          6'h22: alu_c = ALU_SUB;
          6'h24: alu_c = ALU_AND;
          6'h25: alu_c = ALU_OR;
          6'h26: alu_c = ALU_XOR;
          6'h27: alu_c = ALU_NOR;
          6'h2a: alu_c = ALU_SLT;
          6'h2b: alu_c = ALU_SLTU;
          6'h00: begin result_c = RES_SHIFT; us = SH_SLL; end
          6'h02: begin result_c = RES_SHIFT; us = SH_SRL; end
          6'h03: begin result_c = RES_SHIFT; us = SH_SRA; end
          6'h04: begin result_c = RES_SHIFT; us = SH_SLL; sh_d_c = 1'b1; end
          6'h08: begin we_c = 1'b0; pc_next_c = PCN_RS; end
          default: we_c = 1'b0;
        endcase
      end
      6'h08: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; end
      6'h0c: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; ext_c = EXT_ZERO; alu_c = ALU_AND; end
      6'h0d: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; ext_c = EXT_ZERO; alu_c = ALU_OR; end
      6'h0a: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; alu_c = ALU_SLT; end
      6'h0f: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; ext_c = EXT_UPPER; alu_c = ALU_PASSB; end
      6'h23: begin we_c = 1'b1; dest_reg_c = DST_RT; argB_c = 1'b1; result_c = RES_MEM; mem_rd_c = 1'b1; end
      6'h2b: begin argB_c = 1'b1; mem_we_c = 1'b1; end
      6'h04: begin alu_c = ALU_SUB; if (zero) pc_next_c = PCN_BR; end
      6'h05: begin alu_c = ALU_SUB; if (!zero) pc_next_c = PCN_BR; end
      6'h02: pc_next_c = PCN_JUMP;
      6'h03: begin pc_next_c = PCN_JUMP; we_c = 1'b1; dest_reg_c = DST_RA; wd_c = 1'b1; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Serve one memory access at negedge granularity with a given number of wait cycles.
  task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                       input bit data_acc, output int t_start);
    int k;
    k = 0;
    while (!mem_req && k < 16) begin
      if (data_acc) check({tag, "_early_retire"}, 32'(retire), 32'd0);
      @(negedge clk);
      k++;
    end
    t_start = cyc;
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    if (!mem_req) return;
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    if (we) check({tag, "_wdata"}, mem_wdata, wdata);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (data_acc) check({tag, "_wait_retire"}, 32'(retire), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] w, input int fw, input int dw);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa, wr;
    logic [31:0] se, ze, a, b, pc4, npc, wv, ea, ld;
    bit          is_ld, is_st;
    int          t0, t1, tdata, lat, k;
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6]; fn = w[5:0];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'd0, w[15:0]};
    a = rf_m[rs]; b = rf_m[rt];
    pc4 = pc_m + 32'd4; npc = pc4; wr = 5'd0; wv = 32'd0;
    is_ld = 1'b0; is_st = 1'b0; ea = a + se; ld = 32'd0;
    case (op)
      6'h00: begin
        wr = rd;
        case (fn)
          6'h20: wv = a + b;
          6'h22: wv = a - b;
          6'h24: wv = a & b;
          6'h25: wv = a | b;
          6'h26: wv = a ^ b;
          6'h27: wv = ~(a | b);
          6'h2a: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: wv = (a < b) ? 32'd1 : 32'd0;
          6'h00: wv = b << sa;
          6'h02: wv = b >> sa;
          6'h03: wv = $unsigned($signed(b) >>> sa);
          6'h04: wv = b << a[4:0];
          6'h08: begin wr = 5'd0; npc = a; end
          default: wr = 5'd0;
        endcase
      end
      6'h08: begin wr = rt; wv = a + se; end
      6'h0c: begin wr = rt; wv = a & ze; end
      6'h0d: begin wr = rt; wv = a | ze; end
      6'h0a: begin wr = rt; wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0f: begin wr = rt; wv = {w[15:0], 16'd0}; end
      6'h23: begin wr = rt; is_ld = 1'b1; end
      6'h2b: is_st = 1'b1;
      6'h04: if (a == b) npc = pc4 + (se << 2);
      6'h05: if (a != b) npc = pc4 + (se << 2);
      6'h02: npc = {pc4[31:28], w[25:0], 2'b00};
      6'h03: begin npc = {pc4[31:28], w[25:0], 2'b00}; wr = 5'd31; wv = pc4; end
      default: ;
    endcase
    serve("fetch", pc_m, 1'b0, 32'd0, fw, w, 1'b0, t0);
    check("ir_op", 32'(op_c), 32'(op));
    if (is_ld || is_st) begin
      if (is_ld) begin
        if (!dm.exists(ea)) dm[ea] = $urandom;
        ld = dm[ea];
      end else begin
        ld = $urandom;
      end
      serve("data", ea, is_st, b, dw, ld, 1'b1, tdata);
      if (is_st) dm[ea] = b;
      if (is_ld) wv = ld;
    end
    lat = 4 + fw + (is_ld ? 1 + dw : (is_st ? dw : 0));
    k = 0;
    while (!retire && k < 32) begin
      @(negedge clk);
      k++;
    end
    t1 = cyc;
    check("retire", 32'(retire), 32'd1);
    check("latency", 32'(t1 - t0), 32'(lat));
    check("pc_next", pc_val, npc);
    pc_m = npc;
    if (wr != 5'd0) rf_m[wr] = wv;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned pick;
    r = $urandom;
    pick = $urandom_range(0, 21);
    if (pick < 12) return {6'h00, r[25:6], fn_tab[pick]};
    case (pick)
      12: return {6'h08, r[25:0]};
      13: return {6'h0c, r[25:0]};
      14: return {6'h0d, r[25:0]};
      15: return {6'h0a, r[25:0]};
      16: return {6'h0f, 5'd0, r[20:0]};
      17: return {6'h23, r[25:0]};
      18: return {6'h2b, r[25:0]};
      19: return {(r[26] ? 6'h05 : 6'h04), r[25:0]};
      20: return {(r[26] ? 6'h03 : 6'h02), r[25:0]};
      default: return {6'h00, r[25:21], 15'd0, 6'h08};
    endcase
  endfunction

  initial begin
    logic [31:0] w, ea;
    int t, wr0, k;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    pc_m = RST_PC;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", pc_val, RST_PC);
    reset = 1'b0;
    check("release_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, RST_PC);

    run_instr({6'h08, 5'd0, 5'd1, 16'd5}, 0, 0);       // addi $1,$0,5
    run_instr({6'h2b, 5'd0, 5'd1, 16'd8}, 2, 2);       // sw $1,8($0)
    run_instr({6'h23, 5'd0, 5'd2, 16'd8}, 2, 2);       // lw $2,8($0)
    run_instr({6'h2b, 5'd0, 5'd2, 16'd12}, 0, 0);      // sw $2,12($0)
    run_instr({6'h02, 26'h80}, 0, 0);                  // j 0x200
    run_instr({6'h04, 10'd0, 16'hFFFF}, 1, 0);         // beq $0,$0,-1
    run_instr({6'h02, 26'hC0}, 0, 0);                  // j 0x300
    run_instr({6'h03, 26'h100}, 0, 0);                 // jal 0x400
    run_instr({6'h2b, 5'd0, 5'd31, 16'd0}, 0, 1);      // sw $31,0($0)
    run_instr({6'h08, 5'd0, 5'd0, 16'd7}, 0, 0);       // addi $0,$0,7
    run_instr({6'h2b, 5'd0, 5'd0, 16'd16}, 0, 0);      // sw $0,16($0)

    for (int i = 1; i < 32; i++) begin
      w = $urandom;
      run_instr({6'h08, 5'd0, 5'(i), w[15:0]}, int'($urandom_range(0, 2)), 0);
    end
    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    // Reset in the middle of a store's wait state
    w = $urandom;
    w = {6'h2b, w[25:0]};
    ea = rf_m[w[25:21]] + {{16{w[15]}}, w[15:0]};
    serve("rfetch", pc_m, 1'b0, 32'd0, 0, w, 1'b0, t);
    k = 0;
    while (!mem_req && k < 16) begin @(negedge clk); k++; end
    check("rst_mem_addr", mem_addr, ea);
    check("rst_mem_we", 32'(mem_we), 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mem_retire", 32'(retire), 32'd0);
    wr0 = wr_cnt;
    reset = 1'b1;
    #1;
    check("rst_drop_req", 32'(mem_req), 32'd0);
    check("rst_drop_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pc_m = RST_PC;
    check("rst_no_write", 32'(wr_cnt), 32'(wr0));
    @(negedge clk);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, RST_PC);
    check("restart_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 30; i++)
      run_instr(rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    // Timeout: hold ready low on a fetch
    k = 0;
    while (!mem_req && k < 16) begin @(negedge clk); k++; end
    check("to_addr", mem_addr, pc_m);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("to_fault_early", 32'(fault), 32'd0);
    check("to_req_early", 32'(mem_req), 32'd1);
    @(negedge clk);
    check("to_fault", 32'(fault), 32'd1);
    check("to_req_drop", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      check("fault_req", 32'(mem_req), 32'd0);
      check("fault_retire", 32'(retire), 32'd0);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_pc", pc_val, pc_m);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("final_fault_clr", 32'(fault), 32'd0);
    check("final_req", 32'(mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
